spectrum_peak_finder: RTL

//  Sits directly downstream of the cartesian-to-polar CORDIC stage in the FFT postprocess chain.

---
 rtl/spectrum_peak_finder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spectrum_peak_finder.sv
// Tracks the largest-magnitude bin inside [BIN_MIN, BIN_MAX] of each FFT frame
// and reports its bin index, magnitude and phase one cycle after the last bin.
module spectrum_peak_finder #(
    parameter  int WIDTH   = 32,
    parameter  int N_BINS  = 1024,
    parameter  int BIN_MIN = 1,
    parameter  int BIN_MAX = N_BINS / 2 - 1,
    localparam int BIN_W   = $clog2(N_BINS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_vld,
    input  logic                    i_sof,
    input  logic signed [WIDTH-1:0] i_mag,
    input  logic signed [31:0]      i_phase,
    output logic                    o_vld,
    output logic [BIN_W-1:0]        o_bin,
    output logic signed [WIDTH-1:0] o_mag,
    output logic signed [31:0]      o_phase,
    output logic                    o_err,
    output logic [15:0]             o_frame_cnt
);

    localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(BIN_MIN);
    localparam logic [BIN_W-1:0] MAX_IDX  = BIN_W'(BIN_MAX);
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_BINS - 1);

    logic [BIN_W-1:0]        cnt_q, cnt_d;
    logic [BIN_W-1:0]        best_bin_q, best_bin_d;
    logic signed [WIDTH-1:0] best_mag_q, best_mag_d;
    logic signed [31:0]      best_phase_q, best_phase_d;
    logic [BIN_W-1:0]        res_bin_q, res_bin_d;
    logic signed [WIDTH-1:0] res_mag_q, res_mag_d;
    logic signed [31:0]      res_phase_q, res_phase_d;
    logic                    vld_q, vld_d;
    logic                    err_q, err_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;

    logic [BIN_W-1:0] k;
    logic             take;
    logic             last_bin;
    logic             early_sof;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        k         = i_sof ? '0 : cnt_q;
        early_sof = i_vld && i_sof && (cnt_q != '0);
        last_bin  = i_vld && (k == LAST_IDX);

        take = 1'b0;
        if (i_vld) begin
            if (k == MIN_IDX) begin
                take = 1'b1;
            end else if ((k > MIN_IDX) && (k <= MAX_IDX) && (i_mag > best_mag_q)) begin
                take = 1'b1;
            end
        end

        cnt_d        = cnt_q;
        best_bin_d   = best_bin_q;
        best_mag_d   = best_mag_q;
        best_phase_d = best_phase_q;
        res_bin_d    = res_bin_q;
        res_mag_d    = res_mag_q;
        res_phase_d  = res_phase_q;
        frame_cnt_d  = frame_cnt_q;
        vld_d        = last_bin;
        err_d        = early_sof;

        if (i_vld) begin
            cnt_d = last_bin ? '0 : k + BIN_W'(1);
        end

        if (take) begin
            best_bin_d   = k;
            best_mag_d   = i_mag;
            best_phase_d = i_phase;
        end

        // The result includes the final sample, so publish the already-updated best.
        if (last_bin) begin
            res_bin_d   = best_bin_d;
            res_mag_d   = best_mag_d;
            res_phase_d = best_phase_d;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            cnt_q        <= '0;
            best_bin_q   <= '0;
            best_mag_q   <= '0;
            best_phase_q <= '0;
            res_bin_q    <= '0;
            res_mag_q    <= '0;
            res_phase_q  <= '0;
            vld_q        <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            best_bin_q   <= best_bin_d;
            best_mag_q   <= best_mag_d;
            best_phase_q <= best_phase_d;
            res_bin_q    <= res_bin_d;
            res_mag_q    <= res_mag_d;
            res_phase_q  <= res_phase_d;
            vld_q        <= vld_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign o_vld       = vld_q;
    assign o_err       = err_q;
    assign o_bin       = res_bin_q;
    assign o_mag       = res_mag_q;
    assign o_phase     = res_phase_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
